mmio_responder: RTL and testbench

- Memory-mapped I/O target on the fake CPU's data-memory bus. Answers CPU load/store requests in a small register window: console TX FIFO, status, exit/halt register and free-running cycle counter.
- Gives programs an in-band way to print characters and signal completion, instead of relying on a fixed bench timeout.
- Console bytes drain to a downstream valid/ready sink.

---
 rtl/mmio_responder.sv | 172 +++++++++++++++++
 tb/tb_mmio_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// MMIO target for the CPU data bus: console TX FIFO, status, exit/halt and a
// free-running cycle counter in a 16-byte window at BASE_ADDR.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        con_valid,
  input  logic        con_ready,
  output logic [7:0]  con_data,
  output logic        halt,
  output logic [31:0] exit_code,
  output logic [31:0] cycle_count
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] REG_TX     = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_EXIT   = 2'd2;
  localparam logic [1:0] REG_CYCLE  = 2'd3;

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // its response (resp_valid, resp_rdata, resp_err) is presented for exactly
  // the following cycle. The console sink pops on con_valid && con_ready.

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             halt_q, halt_d;
  logic [31:0]      exit_code_q, exit_code_d;
  logic [31:0]      cycle_count_q, cycle_count_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;

  logic       accept;
  logic       addr_hit;
  logic [1:0] reg_sel;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_req;
  logic       push_ok;
  logic       hit_store;
  logic       hit_load;

  always_comb begin
    accept     = req_valid && req_ready;
    addr_hit   = (req_addr[31:4] == BASE_ADDR[31:4]) && (req_addr[1:0] == 2'b00);
    reg_sel    = req_addr[3:2];
    hit_store  = accept && addr_hit && req_we;
    hit_load   = accept && addr_hit && !req_we;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    pop        = !fifo_empty && con_ready;
    push_req   = hit_store && (reg_sel == REG_TX);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    push_ok    = push_req && (!fifo_full || pop);
  end

  // Response path: loads return the pre-edge view of the registers.
  always_comb begin
    resp_valid_d = accept;
    resp_err_d   = accept && !addr_hit;
    resp_rdata_d = 32'd0;
    if (hit_load) begin
      case (reg_sel)
        REG_TX:     resp_rdata_d = 32'(count_q);
        REG_STATUS: resp_rdata_d = {29'd0, overflow_q, fifo_full, fifo_empty};
        REG_EXIT:   resp_rdata_d = exit_code_q;
        REG_CYCLE:  resp_rdata_d = cycle_count_q;
        default:    resp_rdata_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    overflow_d    = overflow_q;
    halt_d        = halt_q;
    exit_code_d   = exit_code_q;
    cycle_count_d = halt_q ? cycle_count_q : cycle_count_q + 32'd1;

    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (hit_store && (reg_sel == REG_STATUS) && req_wdata[2]) begin
      overflow_d = 1'b0;
    end
    if (hit_store && (reg_sel == REG_EXIT)) begin
      halt_d      = 1'b1;
      exit_code_d = req_wdata;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = req_wdata[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      halt_q        <= 1'b0;
      exit_code_q   <= 32'd0;
      cycle_count_q <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'd0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      halt_q        <= halt_d;
      exit_code_q   <= exit_code_d;
      cycle_count_q <= cycle_count_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
    end
  end

  assign req_ready   = !halt_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign con_valid   = !fifo_empty;
  assign con_data    = mem_q[rd_ptr_q];
  assign halt        = halt_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: console FIFO, status/overflow, exit/halt,
// cycle counter, decode errors and reset during a request.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;
  logic        halt;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;

  int n_vec  = 0;
  int n_miss = 0;

  mmio_responder #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .con_valid  (con_valid),
    .con_ready  (con_ready),
    .con_data   (con_data),
    .halt       (halt),
    .exit_code  (exit_code),
    .cycle_count(cycle_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    check("resp_valid", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] r;
    logic        e;
    do_req(1'b1, BASE + off, data, r, e);
    check("wr_err", 32'(e), 32'd0);
    check("wr_rdata", r, 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    do_req(1'b0, BASE + off, 32'd0, r, e);
    check("rd_err", 32'(e), 32'd0);
    check(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic [7:0]  full_exp [8];

    full_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    con_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // reset and idle
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_con_valid", 32'(con_valid), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    repeat (5) step();
    check("idle_cycle5", cycle_count, 32'd5);
    rd("cycle_load", 32'hC, 32'd5);

    // console print
    wr(32'h0, 32'h48);
    wr(32'h0, 32'h69);
    rd("tx_count2", 32'h0, 32'd2);
    rd("status_mid", 32'h4, 32'h0);
    con_ready = 1'b1;
    check("con_v0", 32'(con_valid), 32'd1);
    check("con_d0", 32'(con_data), 32'h48);
    step();
    check("con_v1", 32'(con_valid), 32'd1);
    check("con_d1", 32'(con_data), 32'h69);
    step();
    check("con_drained", 32'(con_valid), 32'd0);
    con_ready = 1'b0;
    rd("status_empty", 32'h4, 32'h1);

    // overflow
    for (int i = 0; i < 9; i++) wr(32'h0, 32'(i));
    rd("status_ovf_full", 32'h4, 32'h6);
    rd("tx_count8", 32'h0, 32'd8);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_v", 32'(con_valid), 32'd1);
      check("ovf_drain_d", 32'(con_data), 32'(i));
      step();
    end
    check("ovf_drained", 32'(con_valid), 32'd0);
    con_ready = 1'b0;
    rd("status_ovf_empty", 32'h4, 32'h5);
    wr(32'h4, 32'h4);
    rd("status_cleared", 32'h4, 32'h1);

    // pointer wrap with push/pop pairs
    for (int k = 0; k < 12; k++) begin
      wr(32'h0, 32'hA0 + 32'(k));
      check("wrap_d", 32'(con_data), 32'hA0 + 32'(k));
      con_ready = 1'b1;
      step();
      con_ready = 1'b0;
      check("wrap_empty", 32'(con_valid), 32'd0);
    end

    // simultaneous push and pop while full
    for (int i = 0; i < 8; i++) wr(32'h0, 32'h10 + 32'(i));
    rd("status_full", 32'h4, 32'h2);
    con_ready = 1'b1;
    wr(32'h0, 32'h55);
    con_ready = 1'b0;
    rd("pp_count", 32'h0, 32'd8);
    rd("pp_status", 32'h4, 32'h2);
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_drain_d", 32'(con_data), 32'(full_exp[i]));
      step();
    end
    check("pp_drained", 32'(con_valid), 32'd0);
    con_ready = 1'b0;

    // decode errors
    do_req(1'b0, BASE + 32'h2, 32'd0, r, e);
    check("misalign_err", 32'(e), 32'd1);
    check("misalign_rdata", r, 32'd0);
    do_req(1'b0, BASE + 32'h10, 32'd0, r, e);
    check("unmapped_err", 32'(e), 32'd1);
    check("unmapped_rdata", r, 32'd0);
    do_req(1'b1, BASE + 32'h1, 32'h77, r, e);
    check("bad_store_err", 32'(e), 32'd1);
    check("bad_store_nopush", 32'(con_valid), 32'd0);
    wr(32'hC, 32'h1234);
    rd("err_tx_count", 32'h0, 32'd0);
    rd("err_status", 32'h4, 32'h1);

    // reset while a request is presented
    wr(32'h0, 32'h33);
    reset     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = BASE + 32'h8;
    req_wdata = 32'h99;
    step();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    check("mid_rst_halt", 32'(halt), 32'd0);
    check("mid_rst_fifo", 32'(con_valid), 32'd0);
    check("mid_rst_cycle", cycle_count, 32'd0);
    reset = 1'b1;

    // exit and halt
    wr(32'h0, 32'h21);
    wr(32'h0, 32'h22);
    rd("exit_load0", 32'h8, 32'd0);
    rd("cycle_load3", 32'hC, 32'd3);
    do_req(1'b1, BASE + 32'h8, 32'h2A, r, e);
    check("exit_err", 32'(e), 32'd0);
    check("exit_rdata", r, 32'd0);
    check("exit_halt", 32'(halt), 32'd1);
    check("exit_code", exit_code, 32'h2A);
    check("exit_req_ready", 32'(req_ready), 32'd0);
    check("exit_cycle", cycle_count, 32'd5);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = BASE;
    step();
    check("halted_no_resp", 32'(resp_valid), 32'd0);
    repeat (9) step();
    req_valid = 1'b0;
    check("frozen_cycle", cycle_count, 32'd5);
    check("halt_sticky", 32'(halt), 32'd1);
    con_ready = 1'b1;
    check("halt_drain_v", 32'(con_valid), 32'd1);
    check("halt_drain_d0", 32'(con_data), 32'h21);
    step();
    check("halt_drain_d1", 32'(con_data), 32'h22);
    step();
    check("halt_drained", 32'(con_valid), 32'd0);
    con_ready = 1'b0;

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
